// File: rtl/delta_reg_pkg.sv
// Shared types and the per-channel change-detect function for the multi-channel delta register bank.
package delta_reg_pkg;

   // Widest channel value the detect function handles; narrower values are zero-extended.
   localparam int unsigned DM_MAX_W = 256;

   typedef enum logic [1:0] {
      DM_ANY  = 2'd0,
      DM_RISE = 2'd1,
      DM_FALL = 2'd2,
      DM_ANY2 = 2'd3
   } delta_mode_t;

   // Zero-extended upper bits are equal in x and s, so they never contribute a delta.
   function automatic logic delta_detect(input logic [DM_MAX_W-1:0] x,
                                         input logic [DM_MAX_W-1:0] s,
                                         input delta_mode_t         mode);
      case (mode)
         DM_RISE: return |(x & ~s);
         DM_FALL: return |(~x & s);
         default: return |(x ^ s);
      endcase
   endfunction

endpackage

// File: rtl/delta_reg_channel.sv
// One monitored channel: sampled value, sticky pending/overflow flags and a saturating change counter.
module delta_reg_channel
   import delta_reg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 8,
   parameter bit          HAS_RESET  = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic [DATA_WIDTH-1:0] value_i,
   input  logic                  det_en_i,
   input  logic                  arm_i,
   input  delta_mode_t           mode_i,
   input  logic                  rd_i,
   output logic [DATA_WIDTH-1:0] value_o,
   output logic                  pending_o,
   output logic                  overflow_o,
   output logic [CNT_WIDTH-1:0]  count_o
);

   logic [DATA_WIDTH-1:0] sv_q;
   logic                  pending_q, pending_d;
   logic                  overflow_q, overflow_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  det_c;

   generate
      if (HAS_RESET) begin : g_sv_rst
         always_ff @(posedge CLK) begin
            if (!RSTN) sv_q <= '0;
            else       sv_q <= value_i;
         end
      end else begin : g_sv_norst
         always_ff @(posedge CLK) sv_q <= value_i;
      end
   endgenerate

   assign det_c = delta_detect(DM_MAX_W'(value_i), DM_MAX_W'(sv_q), mode_i) & det_en_i & arm_i;

   // A new change outranks a same-cycle read; a read racing a change clears nothing.
   always_comb begin
      pending_d  = pending_q;
      overflow_d = overflow_q;
      cnt_d      = cnt_q;

      if (det_c)     pending_d = 1'b1;
      else if (rd_i) pending_d = 1'b0;

      if (det_c && pending_q && !rd_i)        overflow_d = 1'b1;
      else if (rd_i && !(det_c && pending_q)) overflow_d = 1'b0;

      if (rd_i && det_c)  cnt_d = CNT_WIDTH'(1);
      else if (rd_i)      cnt_d = '0;
      else if (det_c)     cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         pending_q  <= 1'b0;
         overflow_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         cnt_q      <= cnt_d;
      end
   end

   assign value_o    = sv_q;
   assign pending_o  = pending_q;
   assign overflow_o = overflow_q;
   assign count_o    = cnt_q;

endmodule

// File: rtl/delta_reg_bank.sv
// Multi-channel delta register bank: per-channel change tracking, channel-addressed read/clear, aggregated IRQ.
module delta_reg_bank
   import delta_reg_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 8,
   parameter bit          HAS_RESET  = 1'b1,
   localparam int unsigned SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         CLK,
   input  logic                         RSTN,
   input  logic [NUM_CH*DATA_WIDTH-1:0] VALUE_IN,
   input  logic [NUM_CH-1:0]            CH_ENABLE,
   input  logic [1:0]                   MODE,
   input  logic                         READ_EVENT,
   input  logic [SEL_W-1:0]             READ_SEL,
   output logic [DATA_WIDTH-1:0]        READ_DATA,
   output logic [CNT_WIDTH-1:0]         READ_COUNT,
   output logic [NUM_CH*DATA_WIDTH-1:0] VALUE_OUT,
   output logic [NUM_CH-1:0]            CHANGE_PENDING,
   output logic [NUM_CH-1:0]            OVERFLOW,
   output logic                         IRQ
);

   logic                 arm_q;
   logic [CNT_WIDTH-1:0] cnt_arr [NUM_CH];
   delta_mode_t          mode_c;

   assign mode_c = delta_mode_t'(MODE);

   // Blocks detection on the first edge out of reset, when the sampled values are stale.
   always_ff @(posedge CLK) begin
      if (!RSTN) arm_q <= 1'b0;
      else       arm_q <= 1'b1;
   end

   for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
      delta_reg_channel #(
         .DATA_WIDTH(DATA_WIDTH),
         .CNT_WIDTH (CNT_WIDTH),
         .HAS_RESET (HAS_RESET)
      ) u_ch (
         .CLK       (CLK),
         .RSTN      (RSTN),
         .value_i   (VALUE_IN[i*DATA_WIDTH +: DATA_WIDTH]),
         .det_en_i  (CH_ENABLE[i]),
         .arm_i     (arm_q),
         .mode_i    (mode_c),
         .rd_i      (READ_EVENT && (32'(READ_SEL) == i)),
         .value_o   (VALUE_OUT[i*DATA_WIDTH +: DATA_WIDTH]),
         .pending_o (CHANGE_PENDING[i]),
         .overflow_o(OVERFLOW[i]),
         .count_o   (cnt_arr[i])
      );
   end

   // Out-of-range selects match no channel and read back as zero.
   always_comb begin
      READ_DATA  = '0;
      READ_COUNT = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (32'(READ_SEL) == i) begin
            READ_DATA  = VALUE_OUT[i*DATA_WIDTH +: DATA_WIDTH];
            READ_COUNT = cnt_arr[i];
         end
      end
   end

   assign IRQ = |CHANGE_PENDING;

endmodule

// File: doc/delta_reg_bank.md
Name: delta_reg_bank

Overview:
Multi-channel successor to the single-channel delta register. Samples NUM_CH read-only values of DATA_WIDTH bits every cycle. Per channel it detects changes with a selectable edge mode and keeps a sticky pending flag, an overflow flag and a saturating change counter, all cleared by a channel-addressed read. It sits between status sources and the CSR/interrupt fabric and drives one aggregated IRQ.

Parameters:
NUM_CH, 4, number of monitored channels (1..32)
DATA_WIDTH, 32, width of each channel value
CNT_WIDTH, 8, width of the per-channel saturating change counter (>=2)
HAS_RESET, 1, 1: sampled values reset to 0; 0: sampled-value flops have no reset (flags and counters are always reset)

Ports:
CLK  in  1  clock
RSTN  in  1  reset, synchronous, active-low
VALUE_IN  in  NUM_CH*DATA_WIDTH  channel values; channel i = bits [i*DATA_WIDTH +: DATA_WIDTH]
CH_ENABLE  in  NUM_CH  per-channel detection enable
MODE  in  2  detection mode: 00 ANY, 01 RISE, 10 FALL, 11 ANY
READ_EVENT  in  1  one-cycle read strobe for channel READ_SEL
READ_SEL  in  max(1,$clog2(NUM_CH))  channel addressed by the read
READ_DATA  out  DATA_WIDTH  sampled value of channel READ_SEL (combinational mux)
READ_COUNT  out  CNT_WIDTH  change counter of channel READ_SEL (combinational mux)
VALUE_OUT  out  NUM_CH*DATA_WIDTH  all sampled values
CHANGE_PENDING  out  NUM_CH  sticky per-channel change flags
OVERFLOW  out  NUM_CH  sticky flag: a change was detected while pending was already set
IRQ  out  1  OR of CHANGE_PENDING

Behaviour:
- Sampled value: sv[i] <= VALUE_IN[i] on every clock edge, regardless of enable or mode. Reset value is 0 when HAS_RESET=1; the flops have no reset when HAS_RESET=0.
- Arm flop: reset to 0, and set to 1 on the first clock edge after RSTN goes high. No detection occurs while arm=0. This prevents a spurious change when the block leaves reset with nonzero VALUE_IN, or with unknown sv when HAS_RESET=0.
- Delta per channel, combinational, where x=VALUE_IN[i] and s=sv[i]:
  - ANY: |(x^s)
  - RISE: |(x&~s)
  - FALL: |(~x&s)
  - Qualified: det[i] = delta & CH_ENABLE[i] & arm.
- Latency: if VALUE_IN differs from the last sample in cycle n, CHANGE_PENDING rises at the edge that ends cycle n, and IRQ rises in the same cycle. VALUE_OUT updates at that same edge.
- rd[i] = READ_EVENT && READ_SEL==i. If READ_SEL >= NUM_CH, the read is ignored and READ_DATA/READ_COUNT return 0.
- Pending, per channel, in priority order:
  - reset -> 0
  - det -> 1 (a new change wins over a simultaneous read)
  - rd -> 0
  - otherwise hold
- Overflow:
  - reset -> 0
  - det & pending & ~rd -> 1
  - rd & ~(det & pending) -> 0
  - otherwise hold
  - Note: det with a simultaneous rd clears nothing and does not set overflow.
- Counter:
  - reset -> 0
  - rd & det -> 1
  - rd -> 0
  - det -> min(cnt+1, 2^CNT_WIDTH-1), saturating
  - otherwise hold
- READ_DATA/READ_COUNT show pre-clear values during the READ_EVENT cycle. The CSR samples them in that cycle.
- Deasserting CH_ENABLE stops new detections but does not clear existing pending, overflow or counter state.
- A MODE change takes effect in the same cycle, with no pipeline.
- Reset mid-operation clears all flags and counters and arm. IRQ is 0 in the cycle after the reset edge.

Decomposition:
- Package delta_reg_pkg holds:
  - typedef enum logic[1:0] delta_mode_t {DM_ANY=0, DM_RISE=1, DM_FALL=2, DM_ANY2=3}
  - function delta_detect(x, s, mode)
- One sub-module, delta_reg_channel: sampled value, pending, overflow and counter for one channel, with inputs det_en, arm, mode, rd. The top level holds arm, a generate loop over NUM_CH instances, the read muxes and IRQ.

Test Plan:
1. Reset release with VALUE_IN ch0=0xDEADBEEF, HAS_RESET=1 -> no pending after the first edge; VALUE_OUT ch0=0xDEADBEEF one edge later; IRQ=0.
2. MODE=ANY, ch1 0x0->0x5 -> CHANGE_PENDING=4'b0010 and IRQ=1 next cycle. Then READ_EVENT, READ_SEL=1 -> READ_DATA=0x5, READ_COUNT=1 in that cycle; pending=0 and count=0 after.
3. MODE=RISE, ch2 0xF->0x0 -> no pending. Then 0x0->0x1 -> pending[2]=1. MODE=FALL with 0x1->0x0 -> pending is set.
4. ch0 changes 3 times without a read -> count=3, OVERFLOW[0]=1. Then a read -> both cleared.
5. Read of ch3 in the same cycle ch3 changes -> pending[3] stays 1, count=1, overflow unchanged.
6. CNT_WIDTH=2, 5 changes -> count saturates at 3. CH_ENABLE[0]=0 plus a change -> no new pending. READ_SEL=5 with NUM_CH=4 -> READ_DATA=0 and no state change.
